sevenseg_digit_scanner: RTL and testbench

Time-multiplexes a multi-digit hex value onto a shared seven-segment bus. Each refresh slot presents one nibble to the downstream registered hex-to-seven-segment decoder and drives the matching digit anode. The anode is delayed one cycle so it lines up with the decoder's registered segment output. A new value is accepted through a load strobe and committed only at a frame boundary, so the display never tears mid-frame.

---
 rtl/sevenseg_digit_scanner_if.sv | 35 +++
 rtl/sevenseg_digit_scanner.sv | 86 ++++++++
 tb/tb_sevenseg_digit_scanner.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_digit_scanner_if.sv
// Bus between a digit-scan controller and its driver: value load path in, scan outputs out.
// The master side supplies the value and load strobe; the slave side produces nibble and anodes.
interface sevenseg_digit_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int DIGIT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic                    blank_lz;
  logic [3:0]              nibble_out;
  logic [DIGIT_W-1:0]      digit_idx;
  logic [NUM_DIGITS-1:0]   anode_out;
  logic                    load_ack;

  modport master (
    output value_in,
    output load,
    output blank_lz,
    input  nibble_out,
    input  digit_idx,
    input  anode_out,
    input  load_ack
  );

  modport slave (
    input  value_in,
    input  load,
    input  blank_lz,
    output nibble_out,
    output digit_idx,
    output anode_out,
    output load_ack
  );
endinterface

// File: rtl/sevenseg_digit_scanner.sv
// Time-multiplexed hex digit scanner: one nibble per refresh slot, anode lagging by one cycle
// to align with a registered segment decoder; new values commit only at frame boundaries.
module sevenseg_digit_scanner #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 100000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input logic                     clk,
  input logic                     rst,
  sevenseg_digit_scanner_if.slave bus
);
  localparam int DIGIT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int VAL_W   = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      r_div_cnt;
  logic [DIGIT_W-1:0]    r_digit_idx;
  logic [VAL_W-1:0]      r_active;
  logic [VAL_W-1:0]      r_pending;
  logic                  r_pending_valid;
  logic                  r_load_ack;
  logic [NUM_DIGITS-1:0] r_anode;

  logic                  w_tick;
  logic                  w_last_digit;
  logic                  w_commit;
  logic                  w_blank;
  logic [NUM_DIGITS-1:0] w_zero_from;
  logic [NUM_DIGITS-1:0] w_anode_on;
  logic [NUM_DIGITS-1:0] w_anode_drv;

  assign w_tick       = (r_div_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_last_digit = (r_digit_idx == DIGIT_W'(NUM_DIGITS - 1));
  assign w_commit     = w_tick && w_last_digit && r_pending_valid;

  // w_zero_from[d] is set when every nibble from d up to the most significant is zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_zero_from[gi] = (r_active[VAL_W-1:4*gi] == '0);
      assign w_anode_on[gi]  = (r_digit_idx == DIGIT_W'(gi)) && !w_blank;
    end
  endgenerate

  assign w_blank     = bus.blank_lz && (r_digit_idx != '0) && w_zero_from[r_digit_idx];
  assign w_anode_drv = ANODE_ACTIVE_LOW ? ~w_anode_on : w_anode_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt       <= '0;
      r_digit_idx     <= '0;
      r_active        <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      r_load_ack      <= 1'b0;
      r_anode         <= {NUM_DIGITS{ANODE_ACTIVE_LOW}};
    end else begin
      r_anode <= w_anode_drv;

      if (w_tick) begin
        r_div_cnt   <= '0;
        r_digit_idx <= w_last_digit ? '0 : r_digit_idx + 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      r_load_ack <= w_commit;
      if (w_commit) begin
        r_active        <= r_pending;
        r_pending_valid <= 1'b0;
      end

      // A load on the commit edge refills pending after the old value has been taken.
      if (bus.load) begin
        r_pending       <= bus.value_in;
        r_pending_valid <= 1'b1;
      end
    end
  end

  assign bus.nibble_out = r_active[4*r_digit_idx +: 4];
  assign bus.digit_idx  = r_digit_idx;
  assign bus.anode_out  = r_anode;
  assign bus.load_ack   = r_load_ack;

endmodule

// File: tb/tb_sevenseg_digit_scanner.sv
// Randomised/directed bench for the digit scanner: a time-based reference model feeds a
// per-cycle expectation queue that a negedge monitor drains and compares.
module tb_sevenseg_digit_scanner;
  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int FRAME = N * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sevenseg_digit_scanner_if #(.NUM_DIGITS(N)) bus ();

  sevenseg_digit_scanner #(
    .NUM_DIGITS(N),
    .REFRESH_DIV(DIV),
    .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] nib;
    logic [1:0] dig;
    logic [3:0] an;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_seen = 0;

  // Reference: position in the scan is derived from cycles elapsed since reset.
  int          m_t = 0;
  logic [15:0] m_act = '0;
  logic [15:0] m_pend = '0;
  bit          m_pv = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    int   cd;
    bit   fe;
    bit   blk;
    if (rst) begin
      m_t = 0; m_act = '0; m_pend = '0; m_pv = 1'b0;
      e.an = 4'hF; e.ack = 1'b0;
    end else begin
      cd  = (m_t / DIV) % N;
      fe  = ((m_t % FRAME) == FRAME - 1);
      blk = bus.blank_lz && (cd > 0) && ((m_act >> (4 * cd)) == 16'h0);
      e.an  = blk ? 4'hF : ~(4'(1) << cd);
      e.ack = fe && m_pv;
      if (e.ack) begin
        m_act = m_pend;
        m_pv  = 1'b0;
      end
      if (bus.load) begin
        m_pend = bus.value_in;
        m_pv   = 1'b1;
      end
      m_t++;
    end
    e.dig = 2'((m_t / DIV) % N);
    e.nib = 4'((m_act >> (4 * ((m_t / DIV) % N))) & 16'hF);
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks += 4;
      if (bus.nibble_out !== e.nib) begin
        errors++; $display("FAIL nibble t=%0t got=%h want=%h", $time, bus.nibble_out, e.nib);
      end
      if (bus.digit_idx !== e.dig) begin
        errors++; $display("FAIL digit_idx t=%0t got=%0d want=%0d", $time, bus.digit_idx, e.dig);
      end
      if (bus.anode_out !== e.an) begin
        errors++; $display("FAIL anode t=%0t got=%b want=%b", $time, bus.anode_out, e.an);
      end
      if (bus.load_ack !== e.ack) begin
        errors++; $display("FAIL load_ack t=%0t got=%b want=%b", $time, bus.load_ack, e.ack);
      end
      if (bus.load_ack === 1'b1) ack_seen++;
    end
  end

  task automatic wait_digit(input int d);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.digit_idx == 2'(d)) return;
    end
    checks++; errors++;
    $display("FAIL wait_digit timeout got=%0d want=%0d", bus.digit_idx, d);
  endtask

  task automatic load_value(input logic [15:0] v);
    bus.value_in = v;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
    $display("load value=%h t=%0t", v, $time);
  endtask

  task automatic check_acks(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s ack_count got=%0d want=%0d", name, got, want);
    end else begin
      $display("ok %s ack_count=%0d", name, got);
    end
  endtask

  int base;

  initial begin
    bus.value_in = 16'h1234;
    bus.load     = 1'b1;
    bus.blank_lz = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    bus.load = 1'b0;
    base = ack_seen;
    repeat (2 * FRAME) @(negedge clk);
    check_acks("reset_no_commit", ack_seen - base, 0);

    // Scan of a freshly loaded value.
    base = ack_seen;
    load_value(16'h1A2F);
    repeat (2 * FRAME + 2) @(negedge clk);
    check_acks("scan", ack_seen - base, 1);

    // Load mid-frame; commit waits for the wrap.
    wait_digit(1);
    base = ack_seen;
    load_value(16'h5555);
    check_acks("mid_frame_hold", ack_seen - base, 0);
    wait_digit(0);
    @(negedge clk);
    check_acks("boundary_commit", ack_seen - base, 1);
    repeat (FRAME) @(negedge clk);

    // Leading-zero blanking.
    bus.blank_lz = 1'b1;
    load_value(16'h0005);
    repeat (2 * FRAME) @(negedge clk);
    load_value(16'h0000);
    repeat (2 * FRAME) @(negedge clk);
    load_value(16'h0300);
    repeat (2 * FRAME) @(negedge clk);

    // Random values with random blanking.
    for (int r = 0; r < 6; r++) begin
      bus.blank_lz = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, FRAME)) @(negedge clk);
      load_value(16'($urandom));
      if ($urandom_range(0, 1) == 1) load_value(16'($urandom_range(0, 255)));
      repeat (FRAME + 4) @(negedge clk);
    end
    repeat (FRAME) @(negedge clk);

    // Overwrite then collision with the commit cycle.
    bus.blank_lz = 1'b0;
    wait_digit(1);
    base = ack_seen;
    load_value(16'h1111);
    @(negedge clk);
    load_value(16'h2222);
    wait_digit(2);
    wait_digit(3);
    repeat (DIV - 1) @(negedge clk);
    load_value(16'h3333);
    @(negedge clk);
    check_acks("overwrite_single_ack", ack_seen - base, 1);
    repeat (FRAME + 2) @(negedge clk);
    check_acks("collision_second_ack", ack_seen - base, 2);

    // Reset mid-frame with a pending value.
    wait_digit(0);
    load_value(16'h7777);
    wait_digit(2);
    base = ack_seen;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * FRAME) @(negedge clk);
    check_acks("reset_discards_pending", ack_seen - base, 0);
    load_value(16'h00A0);
    repeat (2 * FRAME) @(negedge clk);
    check_acks("recovery", ack_seen - base, 1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
